// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drain stage for an 8-bit FIFO. Pops one word at a time through
//               the FIFO read port and serialises it as an 8N1/8N2 UART frame
//               on a single idle-high line.
// Ports       : clk        - rising-edge clock, shared with the FIFO
//               reset      - asynchronous, active-low reset
//               enable     - 1 = start new frames; 0 = finish frame, then hold
//               fifo_empty - FIFO empty flag
//               fifo_data  - FIFO data_out, valid the cycle after fifo_rd_en
//               fifo_rd_en - one-cycle registered pop strobe
//               tx         - registered serial line (mark = 1)
//               busy       - registered, high from pop through last stop cycle
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_idx_w = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_data_last = c_idx_w'(DATA_WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_stop_last = c_idx_w'(STOP_BITS - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_pop   = 3'd1;
    localparam logic [2:0] c_st_start = 3'd2;
    localparam logic [2:0] c_st_data  = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;

    logic [2:0]            r_state;
    logic [c_cnt_w-1:0]    r_baud;
    logic [c_idx_w-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  r_rd_en;
    logic                  r_busy;

    logic [2:0]            w_state_next;
    logic [c_cnt_w-1:0]    w_baud_next;
    logic [c_idx_w-1:0]    w_idx_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_tx_next;
    logic                  w_rd_en_next;
    logic                  w_busy_next;
    logic                  w_bit_end;

    assign w_bit_end = (r_baud == c_baud_last);

    // State register plus the registered datapath and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_rd_en <= w_rd_en_next;
            r_busy  <= w_busy_next;
        end
    end

    // Next-state logic. fifo_empty is only consulted in IDLE, so a pop can
    // never be issued against an empty FIFO.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (enable && !fifo_empty) w_state_next = c_st_pop;
            c_st_pop:   w_state_next = c_st_start;
            c_st_start: if (w_bit_end) w_state_next = c_st_data;
            c_st_data:  if (w_bit_end && (r_idx == c_data_last)) w_state_next = c_st_stop;
            c_st_stop:  if (w_bit_end && (r_idx == c_stop_last)) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // Output/datapath logic. Outputs are derived from the next state so the
    // registered line changes on the same edge as the state itself.
    always_comb begin
        w_baud_next  = '0;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_tx_next    = 1'b1;
        w_rd_en_next = 1'b0;
        w_busy_next  = (w_state_next != c_st_idle);

        if ((r_state == c_st_start) || (r_state == c_st_data) || (r_state == c_st_stop)) begin
            w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        end

        // Bit index counts data bits in DATA and stop bits in STOP; it
        // restarts whenever the state changes at a bit boundary.
        if (r_state == c_st_start) begin
            w_idx_next = '0;
        end else if (((r_state == c_st_data) || (r_state == c_st_stop)) && w_bit_end) begin
            w_idx_next = (w_state_next != r_state) ? '0 : r_idx + 1'b1;
        end

        // The FIFO word is valid in the first START cycle (1-cycle read latency).
        if ((r_state == c_st_start) && (r_baud == '0)) begin
            w_shift_next = fifo_data;
        end else if ((r_state == c_st_data) && w_bit_end) begin
            w_shift_next = r_shift >> 1;
        end

        case (w_state_next)
            c_st_pop:   w_rd_en_next = 1'b1;
            c_st_start: w_tx_next    = 1'b0;
            c_st_data:  w_tx_next    = w_shift_next[0];
            default:    w_tx_next    = 1'b1;
        endcase
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Scoreboard bench for fifo_uart_tx. A queue-based FIFO model
//               feeds the DUT; every pushed word is also queued as expected
//               output; a line monitor captures each frame cycle by cycle and
//               compares it with the ideal waveform computed from the word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int DW    = 8;
    localparam int C     = 4;
    localparam int S     = 1;
    localparam int FRAME = (1 + DW + S) * C;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifoq[$];
    logic [DW-1:0] expq[$];
    int            start_times[$];
    int            starts    = 0;
    int            rd_pulses = 0;
    int            mcyc      = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(C),
        .STOP_BITS   (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy)
    );

    // Ideal line waveform of one frame, one bit per clock cycle.
    function automatic logic [63:0] frame_vec(input logic [DW-1:0] b);
        logic [63:0] v;
        int p;
        v = '0;
        for (int i = 0; i < FRAME; i++) begin
            p = i / C;
            if (p == 0)       v[i] = 1'b0;
            else if (p <= DW) v[i] = b[p-1];
            else              v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] b);
        fifoq.push_back(b);
        expq.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 5000 && !(expq.size() == 0 && fifoq.size() == 0 && busy == 1'b0)) begin
            @(negedge clk);
            #2;
            n++;
        end
        check({name, "_drained"}, int'(n < 5000), 1);
    endtask

    task automatic wait_start(input string name, input int old);
        int n;
        n = 0;
        while (n < 300 && starts == old) begin
            @(negedge clk);
            #2;
            n++;
        end
        check({name, "_start_seen"}, int'(starts > old), 1);
    endtask

    // FIFO model with a 1-cycle registered read: a pop strobe seen during a
    // cycle delivers the head word after the following rising edge.
    initial begin : fifo_model
        bit pop_pending;
        pop_pending = 1'b0;
        fifo_empty  = 1'b1;
        fifo_data   = '0;
        forever begin
            @(clk);
            if (clk) begin
                if (pop_pending && fifoq.size() > 0) fifo_data = fifoq.pop_front();
                pop_pending = 1'b0;
            end else if (fifo_rd_en) begin
                rd_pulses++;
                checks++;
                if (fifo_empty) begin
                    failures++;
                    $display("FAIL rd_en_while_empty: got rd_en=1 with fifo_empty=1, required rd_en=0");
                end
                pop_pending = 1'b1;
            end
            #1 fifo_empty = (fifoq.size() == 0);
        end
    end

    // Line monitor: a falling line starts a frame; every cycle of the frame
    // is captured and compared with the waveform of the oldest expected word.
    initial begin : line_monitor
        logic [63:0]   samp;
        logic [63:0]   expv;
        logic [DW-1:0] e;
        int            idx;
        bit            active;
        active = 1'b0;
        idx    = 0;
        samp   = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx == 1'b0) begin
                    active = 1'b1;
                    samp   = '0;
                    idx    = 1;
                    starts++;
                    start_times.push_back(mcyc);
                end
            end else begin
                samp[idx] = tx;
                idx++;
                if (idx == FRAME) begin
                    active = 1'b0;
                    checks++;
                    if (expq.size() == 0) begin
                        failures++;
                        $display("FAIL frame_unexpected: got line %h, required no frame", samp);
                    end else begin
                        e    = expq.pop_front();
                        expv = frame_vec(e);
                        if (samp !== expv) begin
                            failures++;
                            $display("FAIL frame_bits: got %h, required %h (word %h)", samp, expv, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int            old_starts;
        int            old_rd;
        int            n0;
        int            lat;
        int            busy_cnt;
        bit            bad;
        logic [DW-1:0] discard;

        reset  = 1'b1;
        enable = 1'b1;
        #1 reset = 1'b0;

        // 1: reset held with a non-empty FIFO and enable high
        @(negedge clk);
        push_word(8'h5A);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #2;
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("reset_outputs_quiet", int'(bad), 0);
        check("reset_no_pop", rd_pulses, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_idle("after_reset");

        // 2: single frame 0xA5, latency and busy length
        @(negedge clk);
        old_starts = starts;
        old_rd     = rd_pulses;
        push_word(8'hA5);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            #2;
            if (busy === 1'b1) busy_cnt++;
            if (lat < 0 && starts > old_starts) lat = k;
        end
        check("single_start_latency", lat, 2);
        check("single_busy_cycles", busy_cnt, FRAME + 1);
        check("single_rd_pulses", rd_pulses - old_rd, 1);
        check("single_fifo_empty_after", int'(fifo_empty), 1);
        check("single_busy_low_after", int'(busy), 0);

        // 3: burst of three words, 2-cycle mark gap between frames
        @(negedge clk);
        old_rd = rd_pulses;
        n0     = start_times.size();
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h80);
        wait_idle("burst");
        check("burst_frames", start_times.size() - n0, 3);
        check("burst_rd_pulses", rd_pulses - old_rd, 3);
        if (start_times.size() - n0 == 3) begin
            check("burst_spacing_1", start_times[n0+1] - start_times[n0], FRAME + 2);
            check("burst_spacing_2", start_times[n0+2] - start_times[n0+1], FRAME + 2);
        end

        // 4: empty guard
        old_rd = rd_pulses;
        bad    = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            #2;
            if (tx !== 1'b1) bad = 1'b1;
        end
        check("empty_guard_rd", rd_pulses - old_rd, 0);
        check("empty_guard_tx_mark", int'(bad), 0);

        // 5: enable dropped during data bit 3 of 0x3C
        @(negedge clk);
        old_starts = starts;
        old_rd     = rd_pulses;
        push_word(8'h3C);
        push_word(8'h11);
        push_word(8'h22);
        wait_start("enable_drop", old_starts);
        repeat (C * 4 + 1) @(negedge clk);
        enable = 1'b0;
        repeat (80) @(negedge clk);
        #2;
        check("enable_drop_frames", starts - old_starts, 1);
        check("enable_drop_rd", rd_pulses - old_rd, 1);
        check("enable_drop_fifo_left", fifoq.size(), 2);
        check("enable_drop_busy", int'(busy), 0);

        // 6: reset during data bit 5 of 0x11; 0x22 must follow cleanly
        @(negedge clk);
        enable     = 1'b1;
        old_starts = starts;
        wait_start("reset_mid", old_starts);
        repeat (C * 6 + 1) @(negedge clk);
        #2;
        reset   = 1'b0;
        discard = expq.pop_front();
        #1;
        check("reset_mid_tx", int'(tx), 1);
        check("reset_mid_busy", int'(busy), 0);
        check("reset_mid_rd", int'(fifo_rd_en), 0);
        repeat (3) @(negedge clk);
        reset      = 1'b1;
        old_starts = starts;
        old_rd     = rd_pulses;
        wait_start("after_reset_mid", old_starts);
        wait_idle("after_reset_mid");
        check("after_reset_mid_rd", rd_pulses - old_rd, 1);

        // random words with random spacing
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            push_word(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_idle("random");

        check("final_expected_empty", expq.size(), 0);
        check("final_fifo_empty", fifoq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
